// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle for uart_rx_fifo: FIFO head word, error flags,
// occupancy and overrun status, plus the consumer's ready and clear strobes.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]         rx_data;
    logic                         rx_parity_err;
    logic                         rx_frame_err;
    logic                         rx_break;
    logic                         rx_data_valid;
    logic                         rx_data_ready;
    logic [$clog2(FIFO_DEPTH):0]  rx_fifo_level;
    logic                         rx_overrun;
    logic                         clear_overrun;

    modport master (
        output rx_data, rx_parity_err, rx_frame_err, rx_break, rx_data_valid,
               rx_fifo_level, rx_overrun,
        input  rx_data_ready, clear_overrun
    );

    modport slave (
        input  rx_data, rx_parity_err, rx_frame_err, rx_break, rx_data_valid,
               rx_fifo_level, rx_overrun,
        output rx_data_ready, clear_overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, configurable data/parity/stop format
// and a small output FIFO carrying per-word error flags.
module uart_rx_fifo #(
    parameter int unsigned CLK_FRE     = 50,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_pin,
    uart_rx_fifo_if.master rx_if
);
    localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned CntW  = $clog2(CYCLE);
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned EntW  = DATA_BITS + 3;

    localparam logic [CntW-1:0] CntLast = CntW'(CYCLE - 1);
    localparam logic [CntW-1:0] SampA   = CntW'(CYCLE / 2 - 1);
    localparam logic [CntW-1:0] SampB   = CntW'(CYCLE / 2);
    localparam logic [CntW-1:0] SampC   = CntW'(CYCLE / 2 + 1);
    localparam logic [CntW-1:0] CntVote = CntW'(CYCLE / 2 + 2);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
    localparam logic            StopLast = (STOP_BITS == 2);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CntW-1:0]        cycle_cnt_q, cycle_cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [2:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_bit_q, par_bit_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;

    logic                   fall, vote, push, frame_fin, brk;
    logic [EntW-1:0]        push_word;

    logic [EntW-1:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]        level_q, level_d;
    logic [EntW-1:0]        head_q, head_d;
    logic                   overrun_q, overrun_d;
    logic                   pop, full, push_acc, ovr_set;

    assign fall = prev_q & ~sync2_q;
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // The final stop vote is folded in directly because the push happens on the vote cycle.
    assign frame_fin = frame_err_q | ~vote;
    assign brk       = frame_fin & ~(|data_q) & ((PARITY_MODE == 0) || !par_bit_q);
    assign push_word = {brk, frame_fin, parity_err_q, data_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= StIdle;
            cycle_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            samp_q       <= '0;
            data_q       <= '0;
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx_pin;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        samp_d       = samp_q;
        data_d       = data_q;
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        push         = 1'b0;

        if (state_q != StIdle) begin
            cycle_cnt_d = (cycle_cnt_q == CntLast) ? '0 : cycle_cnt_q + 1'b1;
            if (cycle_cnt_q == SampA) samp_d[0] = sync2_q;
            if (cycle_cnt_q == SampB) samp_d[1] = sync2_q;
            if (cycle_cnt_q == SampC) samp_d[2] = sync2_q;
        end

        unique case (state_q)
            StIdle: begin
                cycle_cnt_d = '0;
                if (fall) begin
                    state_d      = StStart;
                    bit_cnt_d    = '0;
                    stop_cnt_d   = 1'b0;
                    data_d       = '0;
                    par_bit_d    = 1'b0;
                    parity_err_d = 1'b0;
                    frame_err_d  = 1'b0;
                end
            end
            StStart: begin
                if (cycle_cnt_q == CntVote && vote) begin
                    state_d     = StIdle;
                    cycle_cnt_d = '0;
                end else if (cycle_cnt_q == CntLast) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (cycle_cnt_q == CntVote) data_d[bit_cnt_q] = vote;
                if (cycle_cnt_q == CntLast) begin
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (cycle_cnt_q == CntVote) begin
                    par_bit_d    = vote;
                    parity_err_d = ((^data_q) ^ vote) != (PARITY_MODE == 1);
                end
                if (cycle_cnt_q == CntLast) state_d = StStop;
            end
            StStop: begin
                if (cycle_cnt_q == CntVote) begin
                    if (!vote) frame_err_d = 1'b1;
                    if (stop_cnt_q == StopLast) begin
                        push        = 1'b1;
                        state_d     = StIdle;
                        cycle_cnt_d = '0;
                        stop_cnt_d  = 1'b0;
                    end
                end else if (cycle_cnt_q == CntLast) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        pop       = (level_q != '0) && rx_if.rx_data_ready;
        full      = (level_q == LvlFull);
        push_acc  = push && (!full || pop);
        ovr_set   = push && full && !pop;
        wr_ptr_d  = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overrun_d = (overrun_q && !rx_if.clear_overrun) || ovr_set;
        case ({push_acc, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (level_d == '0) begin
            head_d = '0;
        end else if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_word;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_if.rx_data       = head_q[DATA_BITS-1:0];
    assign rx_if.rx_parity_err = head_q[DATA_BITS];
    assign rx_if.rx_frame_err  = head_q[DATA_BITS+1];
    assign rx_if.rx_break      = head_q[DATA_BITS+2];
    assign rx_if.rx_data_valid = (level_q != '0);
    assign rx_if.rx_fifo_level = level_q;
    assign rx_if.rx_overrun    = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver and successor to the basic 8N1 receiver. Data width, parity and stop-bit count are set by parameters. Each bit is sampled three times around mid-bit and decided by majority vote, and short glitches on the start bit are rejected. Received words, with per-word error flags, go into a small FIFO read through a valid/ready handshake, which decouples the line from slow consumers in the CPU I/O path.

Parameters:
CLK_FRE, 50, clock frequency in MHz
BAUD_RATE, 115200, serial baud rate; CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit (integer division)
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, output FIFO entries, power of two, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
rx_pin  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  data at FIFO head, LSB received first
rx_parity_err  output  1  head word parity mismatch (always 0 when PARITY_MODE = 0)
rx_frame_err  output  1  head word had a stop bit sampled low
rx_break  output  1  head word is a break: frame_err set and all data and parity bits 0
rx_data_valid  output  1  FIFO not empty
rx_data_ready  input  1  consumer accepts head word
rx_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
rx_overrun  output  1  sticky: a word was dropped because the FIFO was full
clear_overrun  input  1  synchronous clear of rx_overrun

Behaviour:
- Reset values: rx_data 0, all three error outputs 0, rx_data_valid 0, rx_fifo_level 0, rx_overrun 0, FSM in S_IDLE, all counters 0.
- Synchroniser: two flops on rx_pin, both reset to 1 (line idle). An edge flop holds the previous synced value. A falling edge (prev = 1, synced = 0) in S_IDLE enters S_START with cycle_cnt = 0.
- Sampling in every bit state: samples taken at cycle_cnt = CYCLE/2-1, CYCLE/2 and CYCLE/2+1. Bit value = majority of the 3 samples, valid from CYCLE/2+2. cycle_cnt wraps to 0 at CYCLE-1.
- S_START: if the voted value is 1, it is a false start: return to S_IDLE and push nothing. Otherwise go to S_DATA at the CYCLE-1 wrap.
- S_DATA: the voted bit is stored at index bit_cnt. After DATA_BITS bits, go to S_PARITY if PARITY_MODE != 0, else to S_STOP.
- S_PARITY: the voted bit is compared with the computed parity. Odd mode: XOR of data bits and parity bit must be 1. Even mode: it must be 0. A mismatch sets the word's parity_err.
- S_STOP: each stop bit is voted; any stop bit voted 0 sets frame_err.
  - Final stop bit: the word is pushed at the cycle its vote resolves (CYCLE/2+2), then the FSM goes straight to S_IDLE. This allows resync to a start edge arriving before the nominal stop end.
  - With STOP_BITS = 2, the first stop bit runs the full CYCLE.
- Break: computed at push time as frame_err AND all data bits 0 AND (parity bit 0 or no parity). After a break the FSM returns to S_IDLE, and the next falling edge is not seen until the line goes high again.
- FIFO entry = {break, frame_err, parity_err, data}. Head outputs are registered from storage at the read pointer and are 0 when empty.
  - Push and pop on the same cycle when full: the pop is taken and the push is accepted; no overrun, level unchanged.
  - Push and pop on the same cycle when not empty: level unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; full is level == FIFO_DEPTH.
  - Pop = rx_data_valid && rx_data_ready. The head updates on the next cycle, and a push into an empty FIFO gives rx_data_valid = 1 on the next cycle.
- Overrun: a push while full without a same-cycle pop drops the new word and sets rx_overrun. clear_overrun clears it. A simultaneous clear_overrun and new overrun leaves it set.
- Latency: rx_pin rising at the nominal end of the final stop bit's first half, plus 2 sync cycles plus 3, gives rx_data_valid = 1 (about CYCLE/2+4 clocks after the stop bit starts).
- Reset asserted mid-frame: immediate return to the reset state. The partial word and FIFO contents are discarded.

Test Plan:
- Default params (CYCLE = 434), send 0x55 8N1 with ready = 1 -> one pop: rx_data = 0x55, all error flags 0, rx_fifo_level returns to 0.
- PARITY_MODE = 2, send 0xA3 with parity bit 1 (wrong; correct is 0) -> rx_data = 0xA3, rx_parity_err = 1, rx_frame_err = 0. Resend with parity 0 -> rx_parity_err = 0.
- Low pulse of 100 clocks on an idle line -> no push, rx_data_valid stays 0. A 1-clock glitch at a data bit's mid-sample -> majority vote keeps the correct data, 0x3C received intact.
- Line held low for 12 bit times, then high -> one word: rx_data = 0x00, rx_frame_err = 1, rx_break = 1. A following 0x81 frame is received cleanly.
- ready = 0, send 5 frames 0x01..0x05 with FIFO_DEPTH = 4 -> level 4, rx_overrun = 1. Pops return 0x01..0x04 in order. clear_overrun -> 0.
- DATA_BITS = 7, STOP_BITS = 2; assert rst_n low mid-data of one frame, then release and send 0x5A -> only 0x5A is received, no stale word.
